// File: rtl/sc1602_lcd_ctrl.sv
// HD44780-compatible 4-bit controller for the SC1602 16x2 LCD.
// Runs the power-on init sequence, then sends command/data bytes taken over a
// valid/ready port as two nibble strobes with fixed timing (busy flag never read).
module sc1602_lcd_ctrl #(
    parameter int unsigned CLK_MHZ = 27,
    parameter int unsigned PON_US  = 50000,
    parameter int unsigned T_AS    = 2,
    parameter int unsigned T_EW    = 12,
    parameter int unsigned T_AH    = 2,
    parameter int unsigned CMD_US  = 40,
    parameter int unsigned CLR_US  = 1640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_db,
    output logic [4:0] dbg_state
);

    // Fixed HD44780 init delays.
    localparam int unsigned I0W_US = 4100;
    localparam int unsigned I1W_US = 100;

    // The wait counter must hold the longest of all waits.
    localparam int unsigned MAX_A  = (PON_US > I0W_US) ? PON_US : I0W_US;
    localparam int unsigned MAX_B  = (MAX_A > CLR_US) ? MAX_A : CLR_US;
    localparam int unsigned MAX_US = (MAX_B > CMD_US) ? MAX_B : CMD_US;
    localparam int unsigned CNT_W  = $clog2(MAX_US * CLK_MHZ + 1);

    localparam logic [CNT_W-1:0] PON_LAST = CNT_W'(PON_US * CLK_MHZ - 1);
    localparam logic [CNT_W-1:0] I0W_LAST = CNT_W'(I0W_US * CLK_MHZ - 1);
    localparam logic [CNT_W-1:0] I1W_LAST = CNT_W'(I1W_US * CLK_MHZ - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_US * CLK_MHZ - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_US * CLK_MHZ - 1);

    // Strobe sub-counter: setup (E=0), pulse (E=1), hold (E=0).
    localparam int unsigned      STB_LEN   = T_AS + T_EW + T_AH;
    localparam int unsigned      SUB_W     = $clog2(STB_LEN + 1);
    localparam logic [SUB_W-1:0] STB_LAST  = SUB_W'(STB_LEN - 1);
    localparam logic [SUB_W-1:0] E_ON      = SUB_W'(T_AS);
    localparam logic [SUB_W-1:0] E_OFF     = SUB_W'(T_AS + T_EW);

    localparam logic [2:0] ROM_LEN = 3'd5;

    typedef enum logic [4:0] {
        StPon   = 5'd0,
        StI0    = 5'd1,
        StI0w   = 5'd2,
        StI1    = 5'd3,
        StI1w   = 5'd4,
        StI2    = 5'd5,
        StI2w   = 5'd6,
        StI3    = 5'd7,
        StI3w   = 5'd8,
        StLoad  = 5'd9,
        StHi    = 5'd10,
        StLo    = 5'd11,
        StWait  = 5'd12,
        StIdle  = 5'd13
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [2:0]       rom_idx_q, rom_idx_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             init_done_q, init_done_d;

    logic             in_strobe;
    logic             in_wait;
    logic             strobe_last;
    logic             wait_hit;
    logic             is_clr;
    logic [CNT_W-1:0] wait_last;

    // Init command ROM: function set, display off, clear, entry mode, display on.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h28;
            3'd1:    return 8'h08;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h0C;
        endcase
    endfunction

    // Clear and return-home need the long post-command delay.
    assign is_clr      = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign strobe_last = (sub_q == STB_LAST);
    assign wait_hit    = (cnt_q == wait_last);

    // Classify the current state and pick the terminal count for the wait states.
    always_comb begin
        in_strobe = 1'b0;
        in_wait   = 1'b0;
        wait_last = CMD_LAST;
        case (state_q)
            StPon:  begin in_wait = 1'b1; wait_last = PON_LAST; end
            StI0w:  begin in_wait = 1'b1; wait_last = I0W_LAST; end
            StI1w,
            StI2w:  begin in_wait = 1'b1; wait_last = I1W_LAST; end
            StI3w:  begin in_wait = 1'b1; wait_last = CMD_LAST; end
            StWait: begin in_wait = 1'b1; wait_last = is_clr ? CLR_LAST : CMD_LAST; end
            StI0, StI1, StI2, StI3, StHi, StLo: in_strobe = 1'b1;
            default: ;
        endcase
    end

    // Next-state, counter and byte-capture logic.
    always_comb begin
        state_d     = state_q;
        rom_idx_d   = rom_idx_q;
        data_d      = data_q;
        rs_d        = rs_q;
        cnt_d       = '0;
        sub_d       = '0;

        if (in_wait && !wait_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (in_strobe && !strobe_last) begin
            sub_d = sub_q + 1'b1;
        end

        case (state_q)
            StPon:  if (wait_hit)    state_d = StI0;
            StI0:   if (strobe_last) state_d = StI0w;
            StI0w:  if (wait_hit)    state_d = StI1;
            StI1:   if (strobe_last) state_d = StI1w;
            StI1w:  if (wait_hit)    state_d = StI2;
            StI2:   if (strobe_last) state_d = StI2w;
            StI2w:  if (wait_hit)    state_d = StI3;
            StI3:   if (strobe_last) state_d = StI3w;
            StI3w:  if (wait_hit)    state_d = StLoad;
            StLoad: begin
                data_d    = init_rom(rom_idx_q);
                rs_d      = 1'b0;
                rom_idx_d = rom_idx_q + 1'b1;
                state_d   = StHi;
            end
            StHi:   if (strobe_last) state_d = StLo;
            StLo:   if (strobe_last) state_d = StWait;
            StWait: begin
                if (wait_hit) begin
                    state_d = (rom_idx_q < ROM_LEN) ? StLoad : StIdle;
                end
            end
            StIdle: begin
                if (wr_valid) begin
                    data_d  = wr_data;
                    rs_d    = wr_rs;
                    state_d = StHi;
                end
            end
            default: state_d = StPon;
        endcase

        init_done_d = init_done_q | (state_d == StIdle);
    end

    // State and datapath registers; reset restarts the whole init sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StPon;
            cnt_q       <= '0;
            sub_q       <= '0;
            rom_idx_q   <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            rom_idx_q   <= rom_idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            init_done_q <= init_done_d;
        end
    end

    // Pin drive decoded from registered state, so reset clears E without waiting for a clock.
    always_comb begin
        lcd_rs = 1'b0;
        lcd_db = 4'h0;
        case (state_q)
            StI0, StI1, StI2: lcd_db = 4'h3;
            StI3:             lcd_db = 4'h2;
            StHi:   begin lcd_rs = rs_q; lcd_db = data_q[7:4]; end
            StLo:   begin lcd_rs = rs_q; lcd_db = data_q[3:0]; end
            default: ;
        endcase
        lcd_e     = in_strobe && (sub_q >= E_ON) && (sub_q < E_OFF);
        lcd_rw    = 1'b0;
        wr_ready  = (state_q == StIdle);
        init_done = init_done_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_sc1602_lcd_ctrl.sv
// Self-checking bench for sc1602_lcd_ctrl: a cycle-schedule reference model built
// from the LCD timing rules, plus literal checks of the init and handshake behaviour.
module tb_sc1602_lcd_ctrl;

    localparam int unsigned CLK_MHZ = 1;
    localparam int unsigned PON_US  = 100;
    localparam int unsigned T_AS    = 1;
    localparam int unsigned T_EW    = 2;
    localparam int unsigned T_AH    = 1;
    localparam int unsigned CMD_US  = 40;
    localparam int unsigned CLR_US  = 1640;
    localparam int          BUDGET  = 10000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_rs    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_db;
    logic [4:0] dbg_state;

    sc1602_lcd_ctrl #(
        .CLK_MHZ(CLK_MHZ), .PON_US(PON_US), .T_AS(T_AS), .T_EW(T_EW),
        .T_AH(T_AH), .CMD_US(CMD_US), .CLR_US(CLR_US)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // One expected cycle of DUT outputs; rs/db are only meaningful during strobes.
    typedef struct packed {
        logic       e;
        logic       chk;
        logic       rs;
        logic [3:0] db;
        logic       ready;
        logic [4:0] st;
        logic       done;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         idle;
    bit         need_init = 1'b1;
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         hs_count  = 0;
    logic [3:0] nib_log[$];
    logic       rs_log[$];
    logic [7:0] rom [5] = '{8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
    int         init_nibs [14] = '{3, 3, 3, 2, 2, 8, 0, 8, 0, 1, 0, 6, 0, 12};

    function automatic void check(string name, int got, int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s @%0t: got %0d, required %0d", name, $time, got, expv);
    endfunction

    function automatic int wait_cycles(logic rs, logic [7:0] d);
        if (!rs && d >= 8'd1 && d <= 8'd3) return CLR_US * CLK_MHZ;
        return CMD_US * CLK_MHZ;
    endfunction

    function automatic void push_wait(int n, logic [4:0] st, logic done);
        exp_t x;
        x = '0;
        x.st = st;
        x.done = done;
        for (int i = 0; i < n; i++) q.push_back(x);
    endfunction

    function automatic void push_strobe(logic [4:0] st, logic rs, logic [3:0] nib, logic done);
        exp_t x;
        x = '0;
        x.chk = 1'b1;
        x.rs = rs;
        x.db = nib;
        x.st = st;
        x.done = done;
        for (int i = 0; i < int'(T_AS + T_EW + T_AH); i++) begin
            x.e = (i >= int'(T_AS)) && (i < int'(T_AS + T_EW));
            q.push_back(x);
        end
    endfunction

    function automatic void push_byte(logic rs, logic [7:0] d, logic done);
        push_strobe(5'd10, rs, d[7:4], done);
        push_strobe(5'd11, rs, d[3:0], done);
        push_wait(wait_cycles(rs, d), 5'd12, done);
    endfunction

    function automatic void push_init();
        push_wait(PON_US * CLK_MHZ, 5'd0, 1'b0);
        push_strobe(5'd1, 1'b0, 4'h3, 1'b0);
        push_wait(4100 * CLK_MHZ, 5'd2, 1'b0);
        push_strobe(5'd3, 1'b0, 4'h3, 1'b0);
        push_wait(100 * CLK_MHZ, 5'd4, 1'b0);
        push_strobe(5'd5, 1'b0, 4'h3, 1'b0);
        push_wait(100 * CLK_MHZ, 5'd6, 1'b0);
        push_strobe(5'd7, 1'b0, 4'h2, 1'b0);
        push_wait(CMD_US * CLK_MHZ, 5'd8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_wait(1, 5'd9, 1'b0);
            push_byte(1'b0, rom[i], 1'b0);
        end
    endfunction

    // Cycle-by-cycle compare of every DUT output against the model schedule.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            need_init = 1'b1;
            n_checks++;
            if ({lcd_e, lcd_rw, lcd_rs, lcd_db, wr_ready, init_done, dbg_state} === 11'd0)
                n_pass++;
            else
                $display("FAIL reset_outputs @%0t: e=%b rw=%b rs=%b db=%h rdy=%b done=%b st=%0d, required all 0",
                         $time, lcd_e, lcd_rw, lcd_rs, lcd_db, wr_ready, init_done, dbg_state);
        end else begin
            if (need_init) begin
                push_init();
                need_init = 1'b0;
            end
            idle = (q.size() == 0);
            if (idle) begin
                cur = '0;
                cur.ready = 1'b1;
                cur.st = 5'd13;
                cur.done = 1'b1;
            end else begin
                cur = q.pop_front();
            end
            n_checks++;
            if (lcd_e === cur.e && lcd_rw === 1'b0 && wr_ready === cur.ready &&
                dbg_state === cur.st && init_done === cur.done &&
                (!cur.chk || (lcd_rs === cur.rs && lcd_db === cur.db)))
                n_pass++;
            else
                $display("FAIL cycle_cmp @%0t: got e=%b rw=%b rdy=%b st=%0d done=%b rs=%b db=%h, required e=%b rw=0 rdy=%b st=%0d done=%b rs=%b db=%h (rs/db checked=%b)",
                         $time, lcd_e, lcd_rw, wr_ready, dbg_state, init_done, lcd_rs, lcd_db,
                         cur.e, cur.ready, cur.st, cur.done, cur.rs, cur.db, cur.chk);
            if (wr_valid && wr_ready) hs_count++;
            if (idle && wr_valid) push_byte(wr_rs, wr_data, 1'b1);
        end
    end

    // Record the nibble and RS present at each E rise.
    always @(posedge lcd_e) begin
        nib_log.push_back(lcd_db);
        rs_log.push_back(lcd_rs);
    end

    // Release reset, pester wr_valid during init, and check the init pulse train.
    task automatic run_init();
        bit seen_done;
        int rs_sum;
        @(posedge clk);
        #1;
        nib_log.delete();
        rs_log.delete();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (c == 100) check("pre_rise_e", int'(lcd_e), 0);
            if (c == 101) begin
                check("first_rise_e", int'(lcd_e), 1);
                check("first_rise_db", int'(lcd_db), 3);
            end
            if (init_done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (init_done) wr_valid = 1'b0;
            else begin
                wr_valid = ($urandom_range(0, 3) == 0);
                wr_rs    = 1'($urandom);
                wr_data  = 8'($urandom);
            end
        end
        wr_valid = 1'b0;
        check("init_done_timeout", int'(seen_done), 1);
        check("init_pulse_count", nib_log.size(), 14);
        rs_sum = 0;
        for (int i = 0; i < 14; i++) begin
            check($sformatf("init_nib[%0d]", i),
                  (i < nib_log.size()) ? int'(nib_log[i]) : -1, init_nibs[i]);
            if (i < rs_log.size()) rs_sum += int'(rs_log[i]);
        end
        check("init_rs_all_zero", rs_sum, 0);
    endtask

    // Offer one byte, wait for the handshake, then count cycles until wr_ready returns.
    task automatic do_write(input logic rs, input logic [7:0] d, output int gap);
        bit ok;
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        ok = 1'b0;
        gap = -1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("write_accept_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_rs    = 1'($urandom);
        wr_data  = 8'($urandom);
        if (ok) begin
            for (int i = 1; i <= BUDGET; i++) begin
                @(negedge clk);
                if (wr_ready) begin
                    gap = i;
                    break;
                end
            end
        end
    endtask

    initial begin
        int gap;
        int hs;
        int hs0;
        bit found;
        logic       rs;
        logic [7:0] d;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        run_init();

        // RS=1 data byte: nibbles 4,1 and a short wait.
        nib_log.delete();
        rs_log.delete();
        do_write(1'b1, 8'h41, gap);
        check("gap_0x41", gap, 49);
        check("nib_0x41_hi", (nib_log.size() > 0) ? int'(nib_log[0]) : -1, 4);
        check("nib_0x41_lo", (nib_log.size() > 1) ? int'(nib_log[1]) : -1, 1);
        check("rs_0x41", (rs_log.size() > 1) ? int'(rs_log[0]) + int'(rs_log[1]) : -1, 2);

        // Clear takes the long wait; set-DDRAM-address takes the short one.
        do_write(1'b0, 8'h01, gap);
        check("gap_clear", gap, 1649);
        do_write(1'b0, 8'h80, gap);
        check("gap_0x80", gap, 49);

        // Random bytes, biased towards the clear/home corner.
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            rs = 1'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            do_write(rs, d, gap);
            check($sformatf("gap_rand[%0d]", k), gap,
                  1 + 2 * int'(T_AS + T_EW + T_AH) + wait_cycles(rs, d));
        end

        // Back-to-back writes with wr_valid held high.
        nib_log.delete();
        hs0 = hs_count;
        hs = 0;
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h48;
        for (int i = 0; i < BUDGET && hs < 2; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                hs++;
                @(posedge clk);
                #1;
                if (hs == 1) wr_data = 8'h49;
                else wr_valid = 1'b0;
            end
        end
        wr_valid = 1'b0;
        repeat (120) @(negedge clk);
        check("b2b_handshakes", hs_count - hs0, 2);
        check("b2b_pulses", nib_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            d = (i < 2) ? 8'h48 : 8'h49;
            check($sformatf("b2b_nib[%0d]", i),
                  (i < nib_log.size()) ? int'(nib_log[i]) : -1,
                  (i % 2 == 0) ? int'(d[7:4]) : int'(d[3:0]));
        end

        // Reset while E is high in the high-nibble strobe.
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h5A;
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (wr_ready) break;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lcd_e && dbg_state == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        check("hi_strobe_seen", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_e", int'(lcd_e), 0);
        check("async_rst_state", int'(dbg_state), 0);
        check("async_rst_ready", int'(wr_ready), 0);
        check("async_rst_done", int'(init_done), 0);
        repeat (3) @(posedge clk);
        run_init();

        nib_log.delete();
        do_write(1'b1, 8'h41, gap);
        check("gap_after_reinit", gap, 49);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
